// File: rtl/marb_pkg.sv
// Shared types and constants for the memory-arbiter APB configuration block.
// Contents: register payload types, FSM state encoding, latched request
// payload, the register address map and a byte-lane merge helper.
package marb_pkg;

  localparam int unsigned APB_AW     = 32;
  localparam int unsigned APB_DW     = 32;
  localparam int unsigned APB_SW     = APB_DW / 8;
  localparam int unsigned WAIT_CNT_W = 4;

  localparam logic [APB_AW-1:0] MEM_ARBITER_CTRL_REG_ADDR       = 32'h0000_0000;
  localparam logic [APB_AW-1:0] MEM_ARBITER_STATUS_REG_ADDR     = 32'h0000_0004;
  localparam logic [APB_AW-1:0] MEM_ARBITER_ERRCNT_REG_ADDR     = 32'h0000_0008;
  localparam logic [APB_AW-1:0] MEM_ARBITER_DPRIO_REG_BASE_ADDR = 32'h0000_0010;

  // ctrl[31] doubles as the dprio lock bit when the lock feature is built in
  typedef struct packed {
    logic        lock;
    logic [30:0] cfg;
  } ctrl_reg_t;

  // One dprio word: byte j holds the priority of client 4k+j
  typedef logic [APB_SW-1:0][7:0] dprio_reg_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} apb_state_t;

  typedef struct packed {
    logic              wr;
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
    logic [APB_SW-1:0] strb;
  } apb_req_t;

  // Replace only the byte lanes whose strobe is set
  function automatic logic [APB_DW-1:0] byte_merge(input logic [APB_DW-1:0] old_val,
                                                   input logic [APB_DW-1:0] new_val,
                                                   input logic [APB_SW-1:0] strb);
    logic [APB_DW-1:0] res;
    res = old_val;
    for (int i = 0; i < int'(APB_SW); i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_conf_regs_if.sv
// APB slave bus bundle for the arbiter configuration block.
// master: drives sel/enable/wr/addr/wdata/strb; slave: drives rdata/ready/slverr.
interface apb_conf_regs_if;
  import marb_pkg::*;

  logic              conf_sel;
  logic              conf_enable;
  logic              conf_wr;
  logic [APB_AW-1:0] conf_addr;
  logic [APB_DW-1:0] conf_wdata;
  logic [APB_SW-1:0] conf_strb;
  logic [APB_DW-1:0] conf_rdata;
  logic              conf_ready;
  logic              conf_slverr;

  modport master (
    output conf_sel, conf_enable, conf_wr, conf_addr, conf_wdata, conf_strb,
    input  conf_rdata, conf_ready, conf_slverr
  );

  modport slave (
    input  conf_sel, conf_enable, conf_wr, conf_addr, conf_wdata, conf_strb,
    output conf_rdata, conf_ready, conf_slverr
  );
endinterface

// File: rtl/marb_apb_fsm.sv
// APB transfer sequencer: IDLE -> (WAIT x WAIT_CYCLES_P) -> RESP -> IDLE.
// Ports: clk, rst (sync, active-low), sel, req_in (live bus request),
// req_c (request seen at commit), commit_c (edge entering RESP), ready.
module marb_apb_fsm
  import marb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES_P = 0
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     sel,
  input  apb_req_t req_in,
  output apb_req_t req_c,
  output logic     commit_c,
  output logic     ready
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES_P);

  apb_state_t            state;
  logic [WAIT_CNT_W-1:0] cnt;
  apb_req_t              req_q;

  // With no wait states the commit edge is the sampling edge, so use the live bus
  assign req_c    = (state == IDLE) ? req_in : req_q;
  assign commit_c = ((state == IDLE) && sel && (WAIT_INIT == '0)) ||
                    ((state == WAIT) && (cnt == WAIT_CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      req_q <= '0;
      ready <= 1'b0;
    end else begin
      ready <= commit_c;
      case (state)
        IDLE: begin
          if (sel) begin
            req_q <= req_in;
            cnt   <= WAIT_INIT;
            state <= (WAIT_INIT == '0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - WAIT_CNT_W'(1);
          if (cnt == WAIT_CNT_W'(1)) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/apb_conf_regs.sv
// Memory-arbiter APB configuration registers: CTRL (RW), STATUS (RO),
// ERRCNT (RO, clear-on-read, saturating) and per-client DPRIO words.
// Ports: clk, rst (sync, active-low), bus (APB slave), status (live arbiter
// status), ctrl, dprio (client c at [8c+:8]), dprio_wstrb (per-client pulse).
// Optional build macro MARB_CONF_LOCK_EN: ctrl[31] locks dprio against writes.
module apb_conf_regs
  import marb_pkg::*;
#(
  parameter int unsigned MEM_ARB_CLIENTS_P = 3,
  parameter int unsigned WAIT_CYCLES_P     = 0,
  parameter int unsigned ERRCNT_W_P        = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  apb_conf_regs_if.slave                   bus,
  input  logic [APB_DW-1:0]                status,
  output ctrl_reg_t                        ctrl,
  output logic [MEM_ARB_CLIENTS_P*8-1:0]   dprio,
  output logic [MEM_ARB_CLIENTS_P-1:0]     dprio_wstrb
);

  localparam int unsigned       DPRIO_WORDS = (MEM_ARB_CLIENTS_P + 3) / 4;
  localparam logic [APB_AW-1:0] DPRIO_END   = MEM_ARBITER_DPRIO_REG_BASE_ADDR +
                                              APB_AW'(4 * DPRIO_WORDS);
  localparam logic [APB_AW-3:0] DPRIO_BASE_WORD = MEM_ARBITER_DPRIO_REG_BASE_ADDR[APB_AW-1:2];

  apb_req_t                 req_in;
  apb_req_t                 req_c;
  logic                     commit_c;
  logic                     ready;
  logic [APB_DW-1:0]        rdata_q;
  logic                     slverr_q;
  logic [ERRCNT_W_P-1:0]    errcnt_q;
  logic                     unused_enable;

  // PENABLE carries no information for this sequencer
  assign unused_enable = bus.conf_enable;

  assign req_in = '{wr: bus.conf_wr, addr: bus.conf_addr,
                    wdata: bus.conf_wdata, strb: bus.conf_strb};

  marb_apb_fsm #(.WAIT_CYCLES_P(WAIT_CYCLES_P)) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .sel      (bus.conf_sel),
    .req_in   (req_in),
    .req_c    (req_c),
    .commit_c (commit_c),
    .ready    (ready)
  );

  assign bus.conf_ready  = ready;
  assign bus.conf_rdata  = rdata_q;
  assign bus.conf_slverr = slverr_q;

  logic                        misaligned_c;
  logic                        hit_ctrl_c;
  logic                        hit_status_c;
  logic                        hit_errcnt_c;
  logic                        hit_dprio_c;
  logic                        lock_err_c;
  logic                        err_c;
  logic [APB_AW-3:0]           word_idx_c;
  dprio_reg_t                  dprio_word_c;
  logic [APB_DW-1:0]           rd_c;
  logic [MEM_ARB_CLIENTS_P-1:0] wstrb_c;

  // Address decode, error classification and read mux for the committing request
  always_comb begin
    misaligned_c = req_c.addr[1:0] != 2'b00;
    hit_ctrl_c   = req_c.addr == MEM_ARBITER_CTRL_REG_ADDR;
    hit_status_c = req_c.addr == MEM_ARBITER_STATUS_REG_ADDR;
    hit_errcnt_c = req_c.addr == MEM_ARBITER_ERRCNT_REG_ADDR;
    hit_dprio_c  = !misaligned_c && (req_c.addr >= MEM_ARBITER_DPRIO_REG_BASE_ADDR) &&
                   (req_c.addr < DPRIO_END);
    word_idx_c   = req_c.addr[APB_AW-1:2] - DPRIO_BASE_WORD;
`ifdef MARB_CONF_LOCK_EN
    lock_err_c   = hit_dprio_c && req_c.wr && ctrl.lock;
`else
    lock_err_c   = 1'b0;
`endif
    err_c = misaligned_c ||
            !(hit_ctrl_c || hit_status_c || hit_errcnt_c || hit_dprio_c) ||
            (req_c.wr && (hit_status_c || hit_errcnt_c)) ||
            lock_err_c;

    // Client bytes beyond MEM_ARB_CLIENTS_P read 0 and ignore their strobes
    dprio_word_c = '0;
    wstrb_c      = '0;
    for (int c = 0; c < int'(MEM_ARB_CLIENTS_P); c++) begin
      if (word_idx_c == (APB_AW-2)'(c >> 2)) begin
        dprio_word_c[2'(c)] = dprio[8*c +: 8];
        wstrb_c[c] = commit_c && req_c.wr && !err_c && hit_dprio_c && req_c.strb[2'(c)];
      end
    end

    rd_c = '0;
    if (hit_ctrl_c)        rd_c = ctrl;
    else if (hit_status_c) rd_c = status;
    else if (hit_errcnt_c) rd_c = APB_DW'(errcnt_q);
    else if (hit_dprio_c)  rd_c = dprio_word_c;
  end

  // Register file, response data and error counter all update on the commit edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl        <= '0;
      dprio       <= '0;
      dprio_wstrb <= '0;
      rdata_q     <= '0;
      slverr_q    <= 1'b0;
      errcnt_q    <= '0;
    end else begin
      dprio_wstrb <= wstrb_c;
      rdata_q     <= '0;
      slverr_q    <= 1'b0;
      if (commit_c) begin
        slverr_q <= err_c;
        if (err_c) begin
          if (errcnt_q != '1) errcnt_q <= errcnt_q + ERRCNT_W_P'(1);
        end else if (req_c.wr) begin
          if (hit_ctrl_c) ctrl <= ctrl_reg_t'(byte_merge(ctrl, req_c.wdata, req_c.strb));
        end else begin
          rdata_q <= rd_c;
          if (hit_errcnt_c) errcnt_q <= '0;
        end
      end
      for (int c = 0; c < int'(MEM_ARB_CLIENTS_P); c++) begin
        if (wstrb_c[c]) dprio[8*c +: 8] <= req_c.wdata[8*(c % 4) +: 8];
      end
    end
  end

endmodule
